input_port_buffer: RTL and testbench

- Per-input-port flit buffer and wormhole packet controller; sits directly upstream of the per-port route-compute stage in each router.
- Stores incoming 8-bit flits in a small FIFO and drives the head flit to route compute.
- Latches the returned one-hot route enables for the whole packet, requests the chosen output port from the switch allocator, and streams flits out once granted.
- Flit format: [7:6] type (2'b10 HDR, 2'b00 BODY, 2'b01 TAIL, 2'b11 single-flit HDR+TAIL); [3:2] dest y; [1:0] dest x; [5:4] payload.

---
 rtl/input_port_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_input_port_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_buffer.sv
// Per-input-port flit buffer with a wormhole packet controller.
// Incoming flits are queued in a small FIFO. The head flit goes to route compute,
// and the returned one-hot route is held for the whole packet. The packet is
// streamed to the crossbar once the switch allocator grants the request.
module input_port_buffer #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2,
    parameter int FLIT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLIT_W-1:0]  in_flit,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [FLIT_W-1:0]  Ni,
    input  logic               e1,
    input  logic               e2,
    input  logic               e3,
    input  logic               e4,
    input  logic               e5,
    output logic [4:0]         req,
    input  logic               gnt,
    output logic [FLIT_W-1:0]  out_flit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               pkt_err,
    output logic [DEPTH_W:0]   fifo_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        ACTIVE   = 2'd2,
        DROP     = 2'd3
    } state_t;

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b01;
    localparam logic [1:0] T_HDR  = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    localparam logic [DEPTH_W:0] FULL_COUNT = (DEPTH_W+1)'(DEPTH);

    logic [FLIT_W-1:0]  mem [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] rd_ptr;
    logic [DEPTH_W:0]   count;

    state_t state;
    state_t state_next;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [FLIT_W-1:0]  head;
    logic [1:0]         head_type;
    logic [4:0]         route_en;
    logic               route_onehot;
    logic               req_load;
    logic               req_clear;
    logic               err_now;

    assign full         = (count == FULL_COUNT);
    assign empty        = (count == '0);
    assign push         = in_valid && !full;
    assign head         = mem[rd_ptr];
    assign head_type    = head[FLIT_W-1 -: 2];
    assign route_en     = {e5, e4, e3, e2, e1};
    assign route_onehot = (route_en != 5'd0) && ((route_en & (route_en - 5'd1)) == 5'd0);

    assign in_ready   = !full;
    assign Ni         = empty ? '0 : head;
    assign out_flit   = Ni;
    assign fifo_count = count;

    // Flit storage: data only, so it needs no reset; the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_flit;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Packet controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latched route request; held from header routing until the tail leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req <= 5'd0;
        end else if (req_clear) begin
            req <= 5'd0;
        end else if (req_load) begin
            req <= route_en;
        end
    end

    // Registered error pulse so the output is a clean one-cycle strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_err <= 1'b0;
        end else begin
            pkt_err <= err_now;
        end
    end

    // Next-state, pop decision and output valid for the wormhole controller
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        err_now    = 1'b0;
        req_load   = 1'b0;
        req_clear  = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head_type == T_HDR || head_type == T_HT) begin
                        if (route_onehot) begin
                            req_load   = 1'b1;
                            state_next = WAIT_GNT;
                        end else begin
                            // Unroutable header: discard it, and the rest of the packet if any
                            err_now = 1'b1;
                            pop     = 1'b1;
                            if (head_type == T_HDR) begin
                                state_next = DROP;
                            end
                        end
                    end else begin
                        // Body or tail with no header in front of it
                        err_now = 1'b1;
                        pop     = 1'b1;
                    end
                end
            end
            WAIT_GNT: begin
                if (gnt) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                out_valid = !empty;
                if (!empty && out_ready) begin
                    pop = 1'b1;
                    if (head_type == T_TAIL || head_type == T_HT) begin
                        req_clear  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_type == T_HDR || head_type == T_HT) begin
                        err_now = 1'b1;
                    end
                    // A single-flit packet also carries a tail, so it ends the drop too
                    if (head_type == T_TAIL || head_type == T_HT) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (head_type == T_BODY && state == IDLE && empty) begin
            state_next = IDLE;
        end
    end

endmodule

// File: tb/tb_input_port_buffer.sv
// Self-checking bench for input_port_buffer: table-driven per-cycle vectors
// plus hand-written multi-cycle sequences for backpressure, grant delay,
// bad routes and reset in the middle of a packet.
module tb_input_port_buffer;

    localparam int DEPTH   = 4;
    localparam int DEPTH_W = 2;
    localparam int FLIT_W  = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [FLIT_W-1:0]  in_flit;
    logic               in_valid;
    logic               in_ready;
    logic [FLIT_W-1:0]  Ni;
    logic               e1, e2, e3, e4, e5;
    logic [4:0]         req;
    logic               gnt;
    logic [FLIT_W-1:0]  out_flit;
    logic               out_valid;
    logic               out_ready;
    logic               pkt_err;
    logic [DEPTH_W:0]   fifo_count;

    logic               bad_route;
    logic [4:0]         route;

    int n_cmp  = 0;
    int n_fail = 0;
    int err_pulses = 0;
    int ov_cycles  = 0;

    logic [7:0] exp_flits [8];

    typedef struct {
        logic [7:0] flit;
        logic       vld;
        logic [4:0] exp_req;
        logic       exp_ov;
        logic [2:0] exp_cnt;
        logic [7:0] exp_ni;
        logic       exp_err;
    } vec_t;

    vec_t vecs [15];

    input_port_buffer #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W), .FLIT_W(FLIT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_flit    (in_flit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Ni         (Ni),
        .e1         (e1),
        .e2         (e2),
        .e3         (e3),
        .e4         (e4),
        .e5         (e5),
        .req        (req),
        .gnt        (gnt),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pkt_err    (pkt_err),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Route-compute stand-in: fixed one-hot route per known header flit
    always_comb begin
        route = 5'b00000;
        if (!bad_route) begin
            case (Ni)
                8'h86:   route = 5'b00010;
                8'hC5:   route = 5'b01000;
                8'h80:   route = 5'b00001;
                8'h84:   route = 5'b00100;
                default: route = 5'b00000;
            endcase
        end
    end

    assign {e5, e4, e3, e2, e1} = route;

    // Count error pulses and valid cycles away from the active edge
    always @(negedge clk) begin
        if (pkt_err === 1'b1) err_pulses++;
        if (out_valid === 1'b1) ov_cycles++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] flit, input logic vld);
        in_flit  = flit;
        in_valid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic runVectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(vecs[i].flit, vecs[i].vld);
            checkOutput($sformatf("row%0d req", i), 32'(req), 32'(vecs[i].exp_req));
            checkOutput($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            checkOutput($sformatf("row%0d count", i), 32'(fifo_count), 32'(vecs[i].exp_cnt));
            checkOutput($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_cnt != 3'd4));
            checkOutput($sformatf("row%0d Ni", i), 32'(Ni), 32'(vecs[i].exp_ni));
            checkOutput($sformatf("row%0d out_flit", i), 32'(out_flit), 32'(vecs[i].exp_ni));
            checkOutput($sformatf("row%0d pkt_err", i), 32'(pkt_err), 32'(vecs[i].exp_err));
        end
    endtask

    // Collects flits accepted by the crossbar and compares against exp_flits
    task automatic drainPacket(input string tag, input int n);
        logic [7:0] got [8];
        int         ng;
        int         cyc;
        logic       pushing;
        ng  = 0;
        cyc = 0;
        while (ng < n && cyc < 20) begin
            pushing = in_valid && in_ready;
            if (out_valid && out_ready) begin
                got[ng] = out_flit;
                ng++;
            end
            @(posedge clk);
            #1;
            if (pushing) in_valid = 1'b0;
            cyc++;
        end
        checkOutput({tag, " flits delivered"}, 32'(ng), 32'(n));
        for (int k = 0; k < n && k < ng; k++) begin
            checkOutput($sformatf("%s flit%0d", tag, k), 32'(got[k]), 32'(exp_flits[k]));
        end
        checkOutput({tag, " req cleared"}, 32'(req), 32'd0);
        checkOutput({tag, " count empty"}, 32'(fifo_count), 32'd0);
        checkOutput({tag, " out_valid low"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_err;
        int base_ov;

        // Single packet, then stray body, HDR+TAIL and back-to-back header
        vecs[0]  = '{8'h86, 1'b1, 5'b00000, 1'b0, 3'd1, 8'h86, 1'b0};
        vecs[1]  = '{8'h00, 1'b1, 5'b00010, 1'b0, 3'd2, 8'h86, 1'b0};
        vecs[2]  = '{8'h40, 1'b1, 5'b00010, 1'b1, 3'd3, 8'h86, 1'b0};
        vecs[3]  = '{8'h00, 1'b0, 5'b00010, 1'b1, 3'd2, 8'h00, 1'b0};
        vecs[4]  = '{8'h00, 1'b0, 5'b00010, 1'b1, 3'd1, 8'h40, 1'b0};
        vecs[5]  = '{8'h00, 1'b0, 5'b00000, 1'b0, 3'd0, 8'h00, 1'b0};
        vecs[6]  = '{8'h00, 1'b1, 5'b00000, 1'b0, 3'd1, 8'h00, 1'b0};
        vecs[7]  = '{8'hC5, 1'b1, 5'b00000, 1'b0, 3'd1, 8'hC5, 1'b1};
        vecs[8]  = '{8'h80, 1'b1, 5'b01000, 1'b0, 3'd2, 8'hC5, 1'b0};
        vecs[9]  = '{8'h40, 1'b1, 5'b01000, 1'b1, 3'd3, 8'hC5, 1'b0};
        vecs[10] = '{8'h00, 1'b0, 5'b00000, 1'b0, 3'd2, 8'h80, 1'b0};
        vecs[11] = '{8'h00, 1'b0, 5'b00001, 1'b0, 3'd2, 8'h80, 1'b0};
        vecs[12] = '{8'h00, 1'b0, 5'b00001, 1'b1, 3'd2, 8'h80, 1'b0};
        vecs[13] = '{8'h00, 1'b0, 5'b00001, 1'b1, 3'd1, 8'h40, 1'b0};
        vecs[14] = '{8'h00, 1'b0, 5'b00000, 1'b0, 3'd0, 8'h00, 1'b0};

        rst_n     = 1'b0;
        in_flit   = 8'h00;
        in_valid  = 1'b0;
        gnt       = 1'b0;
        out_ready = 1'b0;
        bad_route = 1'b0;
        #12;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset Ni", 32'(Ni), 32'd0);
        checkOutput("reset req", 32'(req), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset pkt_err", 32'(pkt_err), 32'd0);
        checkOutput("reset count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single packet");
        gnt       = 1'b1;
        out_ready = 1'b1;
        runVectors(0, 5);

        $display("[TB] backpressure");
        gnt       = 1'b1;
        out_ready = 1'b0;
        exp_flits[0] = 8'h80;
        exp_flits[1] = 8'h10;
        exp_flits[2] = 8'h20;
        exp_flits[3] = 8'h30;
        exp_flits[4] = 8'h41;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(exp_flits[k], 1'b1);
            checkOutput($sformatf("bp fill count%0d", k), 32'(fifo_count), 32'(k + 1));
        end
        checkOutput("bp in_ready full", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(exp_flits[4], 1'b1);
            checkOutput($sformatf("bp hold count%0d", k), 32'(fifo_count), 32'd4);
            checkOutput($sformatf("bp hold in_ready%0d", k), 32'(in_ready), 32'd0);
        end
        checkOutput("bp req", 32'(req), 32'b00001);
        checkOutput("bp out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        drainPacket("bp", 5);

        $display("[TB] grant delay");
        gnt       = 1'b0;
        out_ready = 1'b1;
        applyStimulus(8'h84, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h40, 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("gd req%0d", k), 32'(req), 32'b00100);
            checkOutput($sformatf("gd out_valid%0d", k), 32'(out_valid), 32'd0);
            checkOutput($sformatf("gd count%0d", k), 32'(fifo_count), 32'd3);
            if (k < 5) applyStimulus(8'h00, 1'b0);
        end
        gnt = 1'b1;
        applyStimulus(8'h00, 1'b0);
        checkOutput("gd active out_valid", 32'(out_valid), 32'd1);
        checkOutput("gd active count", 32'(fifo_count), 32'd3);
        checkOutput("gd active out_flit", 32'(out_flit), 32'h84);
        exp_flits[0] = 8'h84;
        exp_flits[1] = 8'h00;
        exp_flits[2] = 8'h40;
        drainPacket("gd", 3);

        $display("[TB] bad route");
        bad_route = 1'b1;
        gnt       = 1'b1;
        out_ready = 1'b1;
        base_err  = err_pulses;
        base_ov   = ov_cycles;
        applyStimulus(8'h80, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h40, 1'b1);
        for (int k = 0; k < 4; k++) applyStimulus(8'h00, 1'b0);
        checkOutput("br pkt_err pulses", 32'(err_pulses - base_err), 32'd1);
        checkOutput("br out_valid cycles", 32'(ov_cycles - base_ov), 32'd0);
        checkOutput("br count", 32'(fifo_count), 32'd0);
        checkOutput("br req", 32'(req), 32'd0);
        bad_route = 1'b0;

        $display("[TB] protocol error and back-to-back");
        runVectors(6, 14);

        $display("[TB] reset mid-packet");
        gnt       = 1'b1;
        out_ready = 1'b0;
        applyStimulus(8'h80, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        in_valid = 1'b0;
        checkOutput("rm pre out_valid", 32'(out_valid), 32'd1);
        checkOutput("rm pre count", 32'(fifo_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rm out_valid", 32'(out_valid), 32'd0);
        checkOutput("rm req", 32'(req), 32'd0);
        checkOutput("rm count", 32'(fifo_count), 32'd0);
        checkOutput("rm in_ready", 32'(in_ready), 32'd1);
        checkOutput("rm Ni", 32'(Ni), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rm after req", 32'(req), 32'd0);
        checkOutput("rm after out_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
